// File: rtl/stream_tile_transpose.sv
// stream_tile_transpose
//   Temporal P x P tile transpose for the NTT pipeline. A frame is P
//   consecutive input cycles starting on an inStart cycle; input row r is
//   frame cycle r. Output row k, lane j carries input row j, lane k.
//   Two ping-pong banks let one frame fill while the previous one drains,
//   so back-to-back frames stream at full throughput. Latency from inStart
//   to outStart is P+1 cycles.
//
// Parameters
//   DATA_WIDTH_PER_INPUT  bits per coefficient (W)
//   INPUT_PER_CYCLE       lanes per cycle and tile dimension (P), power of two >= 2
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   inStart   first cycle of an input frame
//   inData    P*W input row, lane c at [c*W +: W]
//   outStart  first cycle of an output frame
//   outData   P*W output row, lane j at [j*W +: W]; zero when not draining
//   outErr    (only with STREAM_TILE_TRANSPOSE_ERR_EN defined) sticky flag,
//             set the cycle after an inStart aborts a partially filled frame
//
// Optional feature macro: STREAM_TILE_TRANSPOSE_ERR_EN

module stream_tile_transpose #(
  parameter int DATA_WIDTH_PER_INPUT = 32,
  parameter int INPUT_PER_CYCLE      = 32
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            inStart,
  input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] inData,
  output logic                                            outStart,
  output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] outData
`ifdef STREAM_TILE_TRANSPOSE_ERR_EN
  ,
  output logic                                            outErr
`endif
);

  localparam int W  = DATA_WIDTH_PER_INPUT;
  localparam int P  = INPUT_PER_CYCLE;
  localparam int RW = $clog2(P);
  localparam logic [RW-1:0] LAST = RW'(P - 1);

  typedef enum logic { W_IDLE, W_FILL  } wstate_t;
  typedef enum logic { R_IDLE, R_DRAIN } rstate_t;

  // Two banks of P rows x P lanes; contents are never reset.
  logic [W-1:0] mem [0:1][0:P-1][0:P-1];

  // Write side
  wstate_t       w_state, w_state_n;
  logic [RW-1:0] wr_row, wr_row_n;
  logic [RW-1:0] wr_sel;
  logic          wr_en;
  logic          fill_bank, fill_bank_n;
  logic          full, full_n;        // one-cycle pulse: a bank just completed
  logic          full_bank;           // which bank that pulse refers to

  // Read side
  rstate_t       r_state, r_state_n;
  logic [RW-1:0] rd_col, rd_col_n;
  logic [RW-1:0] col_sel;
  logic          rd_bank, rd_bank_n;
  logic          bank_sel;
  logic          issue;
  logic [P*W-1:0] col_data;

  always_comb begin
    w_state_n   = w_state;
    wr_row_n    = wr_row;
    fill_bank_n = fill_bank;
    wr_sel      = wr_row;
    wr_en       = 1'b0;
    full_n      = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        if (inStart) begin
          wr_en     = 1'b1;
          wr_sel    = '0;
          wr_row_n  = RW'(1);
          w_state_n = W_FILL;
        end
      end
      W_FILL: begin
        wr_en = 1'b1;
        if (inStart) begin
          // Abort: restart the same bank from row 0 with no toggle.
          wr_sel   = '0;
          wr_row_n = RW'(1);
        end else if (wr_row == LAST) begin
          wr_row_n    = '0;
          w_state_n   = W_IDLE;
          full_n      = 1'b1;
          fill_bank_n = ~fill_bank;
        end else begin
          wr_row_n = wr_row + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state   <= W_IDLE;
      wr_row    <= '0;
      fill_bank <= 1'b0;
      full      <= 1'b0;
      full_bank <= 1'b0;
    end else begin
      w_state   <= w_state_n;
      wr_row    <= wr_row_n;
      fill_bank <= fill_bank_n;
      full      <= full_n;
      if (full_n) full_bank <= fill_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned c = 0; c < P; c++) begin
        mem[fill_bank][wr_sel][c] <= inData[c*W +: W];
      end
    end
  end

  // The full pulse is seen while idle and column 0 is issued in that same
  // cycle into the output register, giving the P+1 latency. A following
  // frame's pulse lands exactly one cycle after the last column is issued,
  // so consecutive drains are contiguous without an explicit hand-over.
  always_comb begin
    r_state_n = r_state;
    rd_col_n  = rd_col;
    rd_bank_n = rd_bank;
    col_sel   = rd_col;
    bank_sel  = rd_bank;
    issue     = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        if (full) begin
          issue     = 1'b1;
          col_sel   = '0;
          bank_sel  = full_bank;
          rd_bank_n = full_bank;
          rd_col_n  = RW'(1);
          r_state_n = R_DRAIN;
        end
      end
      R_DRAIN: begin
        issue = 1'b1;
        if (rd_col == LAST) begin
          rd_col_n  = '0;
          r_state_n = R_IDLE;
        end else begin
          rd_col_n = rd_col + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    col_data = '0;
    for (int unsigned j = 0; j < P; j++) begin
      col_data[j*W +: W] = mem[bank_sel][j][col_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= R_IDLE;
      rd_col   <= '0;
      rd_bank  <= 1'b0;
      outData  <= '0;
      outStart <= 1'b0;
    end else begin
      r_state  <= r_state_n;
      rd_col   <= rd_col_n;
      rd_bank  <= rd_bank_n;
      outData  <= issue ? col_data : '0;
      outStart <= issue && (col_sel == '0);
    end
  end

`ifdef STREAM_TILE_TRANSPOSE_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      outErr <= 1'b0;
    end else if (w_state == W_FILL && inStart) begin
      outErr <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/stream_tile_transpose.md
Name: stream_tile_transpose

Overview:
- Parametrised successor of the fixed single-cycle lane-swap stage permutations in the NTT pipeline.
- Performs a temporal permutation: P×P tile transpose across P consecutive cycles (P = INPUT_PER_CYCLE), needed by later NTT stages whose stride exceeds one cycle's width.
- Ping-pong double buffering sustains back-to-back frames at full throughput.
- Sits between butterfly stages, using the same inStart/outStart framing as other stage blocks.

Parameters:
- DATA_WIDTH_PER_INPUT, 32: bits per coefficient (W).
- INPUT_PER_CYCLE, 32: lanes per cycle and tile dimension (P); power of two, ≥2.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- inStart  input  1  high in the first cycle of an input frame.
- inData  input  P*W  lane c at bits [c*W +: W].
- outStart  output  1  high in the first cycle of an output frame.
- outData  output  P*W  lane j at bits [j*W +: W].

Behaviour:
- Frame: P consecutive cycles starting at an inStart cycle; row r = frame cycle r (0..P-1). Input is ignored outside frames. Gaps between frames are allowed.
- Mapping: output row k, lane j = input row j, lane k.
- Storage: two banks (A, B), each P×P×W registers. Fill bank toggles after each completed frame and starts at A after reset.
- Write FSM, states W_IDLE and W_FILL, row counter wr_row of log2(P) bits:
  - W_IDLE, inStart=1: write row 0 to the fill bank, wr_row←1, go to W_FILL.
  - W_FILL: write row wr_row, wr_row+1.
  - W_FILL at row P-1: mark the bank full, toggle the fill bank, return to W_IDLE. If inStart=1 on the cycle after, a new frame begins immediately with no bubble.
  - W_FILL with inStart=1 at rows 1..P-1: the partial frame is discarded. The current cycle becomes row 0 of the same bank, wr_row←1, no toggle.
- Read FSM, states R_IDLE and R_DRAIN, column counter rd_col:
  - On the cycle after a bank is marked full, go to R_DRAIN with rd_col=0.
  - Each cycle in R_DRAIN: outData ← column rd_col of the drain bank (registered); outStart=1 only when rd_col=0.
  - After rd_col=P-1: if the other bank has just become full, continue directly with its column 0 and outStart=1. Otherwise go to R_IDLE.
- Latency: inStart in cycle 0 → outStart and output row 0 in cycle P+1. Output row k appears in cycle P+1+k.
- Outside R_DRAIN: outData=0, outStart=0.
- No overflow is possible: fill takes ≥P cycles and drain takes exactly P cycles, so a bank is never refilled before it is drained. Simultaneous fill of one bank and drain of the other is the normal case.
- Reset (at any time, including mid-frame or mid-drain):
  - next cycle outData=0 and outStart=0;
  - both FSMs idle, counters 0, full flags cleared, fill bank = A;
  - partial frames and pending output are discarded;
  - bank contents need not be cleared.
- P=2 is legal and behaves identically with 1-bit counters.

Optional Feature:
- Macro: STREAM_TILE_TRANSPOSE_ERR_EN.
- Defined: adds output port outErr (1 bit). outErr is a sticky flag, set on the cycle after any inStart received while in W_FILL (an aborted frame). It is cleared only by rst, with reset value 0. Datapath behaviour is unchanged.
- Undefined: no outErr port and no flag logic. Aborts are silent.

Test Plan:
- Single frame, P=4, W=8: inStart in cycle 0; rows 0..3 with lane c = 16r+c → outStart in cycle 5 only. Cycles 5..8 carry lane j = 16j+k (e.g. cycle 5 = {0x30,0x20,0x10,0x00} MSB→LSB). outData=0 in cycle 9.
- Back-to-back, P=4: three frames with inStart in cycles 0, 4, 8 (frame f values 64f+16r+c) → outStart in cycles 5, 9, 13. Twelve contiguous correctly transposed rows, no bubble.
- Abort, P=4: inStart in cycle 0, second inStart in cycle 2, data 0xA0+16r+c from cycle 2 → first partial frame discarded. outStart only in cycle 7, carrying the second frame transposed. With the macro, outErr=1 from cycle 3.
- Reset mid-drain, P=4: after the single-frame case, rst in cycle 6 → outData=0 and outStart=0 from cycle 7. A new frame with inStart in cycle 8 yields outStart in cycle 13 with correct data.
- Default P=32, W=32: 4 random back-to-back frames plus one with a 3-cycle gap → each output row k lane j equals input row j lane k, checked against a scoreboard. outStart is spaced exactly 32 cycles apart, with gaps only where input gaps exist.
